io_interval_timer: RTL and testbench

Bus-attached 16-bit programmable interval timer for the 8088 system, occupying the 16-byte I/O window selected by CS3 (0x0FF00–0x0FF0F). It sits downstream of the address latch, the 8286 transceiver and the chip-select decode. It follows the same ALE/RD/WR bus-cycle protocol as the memory/IO peripherals on the `Peripheral` modport. It provides a prescaled down-counter with one-shot and periodic modes, a sticky terminal flag and a level interrupt request.

---
 rtl/io_interval_timer.sv | 190 +++++++++++++++++++
 tb/tb_io_interval_timer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_interval_timer.sv
// Bus-attached 16-bit programmable interval timer on the CS3 I/O window.
// ALE/RD/WR bus-cycle FSM, prescaled down-counter, sticky TF and level IRQ.
`timescale 1ns/1ps
module io_interval_timer #(
  parameter logic [7:0] PRESCALE_RESET = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ALE,
  input  logic        RD,
  input  logic        WR,
  input  logic        CS,
  input  logic [19:0] Address,
  inout  wire  [7:0]  Data,
  output logic        IRQ
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEL   = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [3:0] A_RELOAD_LO = 4'h0;
  localparam logic [3:0] A_RELOAD_HI = 4'h1;
  localparam logic [3:0] A_COUNT_LO  = 4'h2;
  localparam logic [3:0] A_COUNT_HI  = 4'h3;
  localparam logic [3:0] A_CTRL      = 4'h4;
  localparam logic [3:0] A_STATUS    = 4'h5;
  localparam logic [3:0] A_PRESCALE  = 4'h6;

  logic [1:0]  state;
  logic [3:0]  offset;
  logic [15:0] reload;
  logic [15:0] count;
  logic [7:0]  prescale;
  logic [7:0]  pc;
  logic [7:0]  shadow_hi;
  logic        en;
  logic        auto_rl;
  logic        ie;
  logic        tf;

  logic        read_seen;
  logic [7:0]  rd_hold;
  logic [7:0]  rd_mux;
  logic        drive;
  logic        wr_strobe;
  logic        tick;
  logic        terminal;
  logic        snap;
  logic        unused_addr;

  assign unused_addr = ^Address[19:4];

  // RD has priority over WR in SEL, so a write only happens when RD is idle.
  assign wr_strobe = (state == S_SEL) && RD && !WR;
  assign tick      = en && (pc == prescale);
  assign terminal  = tick && (count <= 16'd1);
  assign snap      = (state == S_READ) && !read_seen && (offset == A_COUNT_LO);
  assign drive     = (state == S_READ) && !RD;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= S_IDLE;
      offset <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ALE && CS) begin
            state  <= S_SEL;
            offset <= Address[3:0];
          end
        end
        S_SEL: begin
          if (!RD) begin
            state <= S_READ;
          end else if (!WR) begin
            state <= S_WRITE;
          end else if (ALE && !CS) begin
            state <= S_IDLE;
          end else if (ALE && CS) begin
            offset <= Address[3:0];
          end
        end
        S_READ: begin
          if (RD) state <= S_IDLE;
        end
        S_WRITE: begin
          if (WR) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (offset)
      A_RELOAD_LO: rd_mux = reload[7:0];
      A_RELOAD_HI: rd_mux = reload[15:8];
      A_COUNT_LO:  rd_mux = count[7:0];
      A_COUNT_HI:  rd_mux = shadow_hi;
      A_CTRL:      rd_mux = {5'b0, ie, auto_rl, en};
      A_STATUS:    rd_mux = {7'b0, tf};
      A_PRESCALE:  rd_mux = prescale;
      default:     rd_mux = '0;
    endcase
  end

  // Registers are sampled in the first READ cycle and held for the rest of
  // the strobe, so a long read cannot tear against a running counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      read_seen <= 1'b0;
      rd_hold   <= '0;
    end else if (state == S_READ) begin
      if (!read_seen) begin
        read_seen <= 1'b1;
        rd_hold   <= rd_mux;
      end
    end else begin
      read_seen <= 1'b0;
    end
  end

  assign Data = drive ? (read_seen ? rd_hold : rd_mux) : 8'bz;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shadow_hi <= '0;
    end else if (snap) begin
      shadow_hi <= count[15:8];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      reload   <= '0;
      count    <= '0;
      prescale <= PRESCALE_RESET;
      pc       <= '0;
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      ie       <= 1'b0;
      tf       <= 1'b0;
    end else begin
      if (en) begin
        pc <= tick ? 8'd0 : pc + 8'd1;
      end
      if (tick) begin
        if (terminal) begin
          tf <= 1'b1;
          if (auto_rl) begin
            count <= reload;
          end else begin
            count <= '0;
            en    <= 1'b0;
          end
        end else begin
          count <= count - 16'd1;
        end
      end
      // Bus writes come last so they override same-edge counter updates,
      // except that a terminal TF set beats a TF clear.
      if (wr_strobe) begin
        case (offset)
          A_RELOAD_LO: reload[7:0]  <= Data;
          A_RELOAD_HI: reload[15:8] <= Data;
          A_CTRL: begin
            en      <= Data[0];
            auto_rl <= Data[1];
            ie      <= Data[2];
            if (Data[0] && !en) begin
              count <= reload;
              pc    <= '0;
            end
          end
          A_STATUS: begin
            if (Data[0] && !terminal) tf <= 1'b0;
          end
          A_PRESCALE: prescale <= Data;
          default: ;
        endcase
      end
    end
  end

  assign IRQ = tf & ie;

endmodule

// File: tb/tb_io_interval_timer.sv
// Scoreboard bench for io_interval_timer: stimulus queues expected read data
// and IRQ rise cycles; a monitor pops and compares on every bus read / IRQ rise.
`timescale 1ns/1ps
module tb_io_interval_timer;

  logic        CLK;
  logic        RESET;
  logic        ALE;
  logic        RD;
  logic        WR;
  logic        CS;
  logic [19:0] Address;
  wire  [7:0]  Data;
  logic        IRQ;

  logic        tb_drv;
  logic [7:0]  tb_wdata;

  assign Data = tb_drv ? tb_wdata : 8'bz;
  pullup (Data);

  io_interval_timer #(.PRESCALE_RESET(8'h3C)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ALE     (ALE),
    .RD      (RD),
    .WR      (WR),
    .CS      (CS),
    .Address (Address),
    .Data    (Data),
    .IRQ     (IRQ)
  );

  typedef struct {
    logic [3:0] off;
    logic [7:0] val;
    logic       z;
  } rd_t;

  rd_t  rq[$];
  int   iq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   wr_edge = 0;
  int   E;
  logic irq_prev = 1'b0;
  rd_t  it;
  int   exp_edge;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic released();
    return (Data === 8'hFF) || (Data === 8'hzz);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: one sample per cycle, just after the active edge.
  always begin
    @(posedge CLK);
    #1;
    if (RD === 1'b0) begin
      if (rq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got %0h expected no read (cycle %0d)", Data, cyc);
      end else begin
        it = rq.pop_front();
        if (it.z) chk("bus_release", {31'd0, released()}, 32'd1);
        else      chk($sformatf("rd_off%0h", it.off), {24'd0, Data}, {24'd0, it.val});
      end
    end
    if (IRQ && !irq_prev) begin
      if (iq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL irq_unexpected: got rise at %0d expected none", cyc);
      end else begin
        exp_edge = iq.pop_front();
        chk("irq_rise_cycle", cyc, exp_edge);
      end
    end
    irq_prev = IRQ;
  end

  task automatic sync(input int t);
    if (cyc > t) begin
      tests++;
      fails++;
      $display("FAIL sched: got cycle %0d expected <= %0d", cyc, t);
    end
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic bus_rd(input logic [3:0] off, input logic [7:0] exp);
    rq.push_back('{off, exp, 1'b0});
    @(negedge CLK); ALE = 1'b1; CS = 1'b1; Address = {16'h0FF0, off};
    @(negedge CLK); ALE = 1'b0; CS = 1'b0; RD = 1'b0;
    @(negedge CLK); RD = 1'b1;
  endtask

  task automatic bus_wr(input logic [3:0] off, input logic [7:0] d);
    @(negedge CLK); ALE = 1'b1; CS = 1'b1; Address = {16'h0FF0, off};
    @(negedge CLK); ALE = 1'b0; CS = 1'b0; WR = 1'b0; tb_drv = 1'b1; tb_wdata = d;
    wr_edge = cyc + 1;
    @(negedge CLK); WR = 1'b1; tb_drv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; ALE = 1'b0; CS = 1'b0; RD = 1'b1; WR = 1'b1;
    Address = '0; tb_drv = 1'b0; tb_wdata = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    chk("irq_reset", {31'd0, IRQ}, 32'd0);
    bus_rd(4'h6, 8'h3C);
    bus_rd(4'h4, 8'h00);

    // Dirty every register, then reset in the middle of a CTRL read.
    bus_wr(4'h6, 8'h00);
    bus_wr(4'h0, 8'h01);
    bus_wr(4'h4, 8'h05);
    iq.push_back(wr_edge + 1);
    bus_wr(4'h1, 8'h02);
    bus_wr(4'h6, 8'h11);
    bus_wr(4'h4, 8'h07);
    bus_rd(4'h2, 8'h01);
    bus_rd(4'h3, 8'h02);
    rq.push_back('{4'h4, 8'h07, 1'b0});
    @(negedge CLK); ALE = 1'b1; CS = 1'b1; Address = 20'h0FF04;
    @(negedge CLK); ALE = 1'b0; CS = 1'b0; RD = 1'b0;
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("rst_data_release", {31'd0, released()}, 32'd1);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    @(negedge CLK); RESET = 1'b0; RD = 1'b1;
    bus_rd(4'h0, 8'h00);
    bus_rd(4'h1, 8'h00);
    bus_rd(4'h2, 8'h00);
    bus_rd(4'h3, 8'h00);
    bus_rd(4'h4, 8'h00);
    bus_rd(4'h5, 8'h00);
    bus_rd(4'h6, 8'h3C);

    // Periodic: RELOAD=5, PRESCALE=3 -> TF every 20 clocks.
    bus_wr(4'h0, 8'h05);
    bus_wr(4'h1, 8'h00);
    bus_wr(4'h6, 8'h03);
    bus_wr(4'h4, 8'h07);
    E = wr_edge;
    iq.push_back(E + 20);
    bus_rd(4'h2, 8'h05);
    sync(E + 3);  bus_rd(4'h2, 8'h04);
    sync(E + 7);  bus_rd(4'h2, 8'h03);
    sync(E + 11); bus_rd(4'h2, 8'h02);
    sync(E + 15); bus_rd(4'h2, 8'h01);
    sync(E + 19); bus_rd(4'h2, 8'h05);
    sync(E + 22); bus_wr(4'h5, 8'h01);
    chk("periodic_clear_irq", {31'd0, IRQ}, 32'd0);
    iq.push_back(E + 40);
    sync(E + 39); bus_rd(4'h2, 8'h05);
    bus_wr(4'h4, 8'h04);
    chk("ie_hold_irq", {31'd0, IRQ}, 32'd1);
    bus_wr(4'h5, 8'h01);
    chk("stop_clear_irq", {31'd0, IRQ}, 32'd0);
    bus_rd(4'h2, 8'h04);
    bus_rd(4'h2, 8'h04);

    // One-shot: RELOAD=3, PRESCALE=0.
    bus_wr(4'h0, 8'h03);
    bus_wr(4'h1, 8'h00);
    bus_wr(4'h6, 8'h00);
    bus_wr(4'h4, 8'h01);
    bus_rd(4'h5, 8'h01);
    bus_rd(4'h4, 8'h00);
    bus_rd(4'h2, 8'h00);
    bus_rd(4'h3, 8'h00);
    bus_wr(4'h5, 8'h01);
    bus_rd(4'h5, 8'h00);
    bus_wr(4'h4, 8'h05);
    iq.push_back(wr_edge + 3);
    bus_rd(4'h5, 8'h01);
    bus_wr(4'h5, 8'h01);
    chk("oneshot_clear_irq", {31'd0, IRQ}, 32'd0);

    // Coherent 16-bit read across the 0x0100 reload point.
    bus_wr(4'h0, 8'h00);
    bus_wr(4'h1, 8'h01);
    bus_wr(4'h4, 8'h03);
    E = wr_edge;
    bus_rd(4'h2, 8'hFD);
    bus_rd(4'h3, 8'h00);
    sync(E + 253); bus_rd(4'h2, 8'h00);
    bus_rd(4'h3, 8'h01);
    bus_wr(4'h4, 8'h00);
    bus_wr(4'h5, 8'h01);
    bus_rd(4'h5, 8'h00);

    // TF clear written on the exact edge of a terminal tick.
    bus_wr(4'h0, 8'h04);
    bus_wr(4'h1, 8'h00);
    bus_wr(4'h4, 8'h07);
    E = wr_edge;
    iq.push_back(E + 4);
    sync(E + 5); bus_wr(4'h5, 8'h01);
    chk("collide_edge", wr_edge, E + 8);
    chk("collide_irq", {31'd0, IRQ}, 32'd1);
    bus_rd(4'h5, 8'h01);
    sync(E + 11); bus_wr(4'h5, 8'h01);
    chk("collide_later_clear", {31'd0, IRQ}, 32'd0);
    iq.push_back(E + 16);
    bus_wr(4'h4, 8'h04);
    bus_wr(4'h5, 8'h01);
    chk("collide_final_clear", {31'd0, IRQ}, 32'd0);

    // Decode: CS=0 cycles, then the unused offsets 7..F.
    rq.push_back('{4'h4, 8'h00, 1'b1});
    @(negedge CLK); ALE = 1'b1; CS = 1'b0; Address = 20'h0FF04;
    @(negedge CLK); ALE = 1'b0; RD = 1'b0;
    @(negedge CLK); RD = 1'b1;
    @(negedge CLK); ALE = 1'b1; CS = 1'b0; Address = 20'h0FF04;
    @(negedge CLK); ALE = 1'b0; WR = 1'b0; tb_drv = 1'b1; tb_wdata = 8'h00;
    @(negedge CLK); WR = 1'b1; tb_drv = 1'b0;
    for (int unsigned a = 7; a < 16; a++) bus_wr(4'(a), 8'hA5);
    for (int unsigned a = 7; a < 16; a++) bus_rd(4'(a), 8'h00);
    bus_rd(4'h0, 8'h04);
    bus_rd(4'h1, 8'h00);
    bus_rd(4'h2, 8'h03);
    bus_rd(4'h3, 8'h00);
    bus_rd(4'h4, 8'h04);
    bus_rd(4'h5, 8'h00);
    bus_rd(4'h6, 8'h00);

    repeat (4) @(negedge CLK);
    chk("rd_queue_drained", rq.size(), 32'd0);
    chk("irq_queue_drained", iq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
